// File: rtl/trade_sequencer_if.sv
// trade_sequencer_if: control, input-beat and order-stream signals of the trade sequencer
interface trade_sequencer_if;
  logic        enable;
  logic        kill_clear;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] signal_in;
  logic        allow_trade_in;
  logic        kill_in;
  logic        ord_valid;
  logic        ord_ready;
  logic        ord_side;
  logic [31:0] ord_strength;
  logic [1:0]  state_out;
  logic        halted;
  logic [15:0] drop_count;
  modport slave (
    input  enable, kill_clear, in_valid, signal_in, allow_trade_in, kill_in, ord_ready,
    output in_ready, ord_valid, ord_side, ord_strength, state_out, halted, drop_count
  );
  modport master (
    output enable, kill_clear, in_valid, signal_in, allow_trade_in, kill_in, ord_ready,
    input  in_ready, ord_valid, ord_side, ord_strength, state_out, halted, drop_count
  );
endinterface

// File: rtl/trade_sequencer.sv
// trade_sequencer: turns qualifying signal beats into rate-limited orders with cooldown and kill halt
module trade_sequencer #(
  parameter logic signed [31:0] THRESH = 32'sh0000_8000,
  parameter int COOLDOWN_CYC = 8,
  parameter int MAX_ORDERS = 4,
  parameter int REFILL_CYC = 16
) (
  input logic clk,
  input logic rst_n,
  trade_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ARMED, COOLDOWN, HALTED} state_t;
  state_t      r_state, w_next;
  logic [3:0]  r_tokens;
  logic [15:0] r_refill;
  logic [7:0]  r_cd;
  logic        r_ord_valid;
  logic        r_ord_side;
  logic [31:0] r_ord_strength;
  logic [15:0] r_drop;
  logic [31:0] w_abs;
  logic        w_acc, w_kill, w_qual, w_issue, w_drop, w_pop, w_refill;
  assign w_abs = bus.signal_in == 32'h8000_0000 ? 32'h7FFF_FFFF :
                 bus.signal_in[31] ? -bus.signal_in : bus.signal_in;
  assign w_qual = bus.allow_trade_in && !bus.kill_in && $signed(w_abs) > THRESH;
  // Backpressure only while an unpopped order would be overwritten
  assign bus.in_ready = !rst_n || r_state != ARMED || !r_ord_valid || bus.ord_ready;
  assign w_acc = bus.in_valid && bus.in_ready;
  assign w_kill = w_acc && bus.kill_in;
  assign w_pop = r_ord_valid && bus.ord_ready;
  assign w_issue = r_state == ARMED && bus.enable && w_acc && w_qual && r_tokens != 4'd0;
  assign w_drop = r_state == ARMED && bus.enable && w_acc && w_qual && r_tokens == 4'd0;
  assign w_refill = r_state != HALTED && r_refill == 16'(REFILL_CYC - 1);
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:     w_next = bus.enable ? ARMED : IDLE;
      ARMED:    w_next = w_kill ? HALTED : !bus.enable ? IDLE : w_issue ? COOLDOWN : ARMED;
      COOLDOWN: w_next = w_kill ? HALTED : !bus.enable ? IDLE : r_cd <= 8'd1 ? ARMED : COOLDOWN;
      HALTED:   w_next = bus.kill_clear && !w_kill ? IDLE : HALTED;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_ord_valid    <= 1'b0;
      r_ord_side     <= 1'b0;
      r_ord_strength <= '0;
      r_tokens       <= 4'(MAX_ORDERS);
      r_refill       <= '0;
      r_cd           <= '0;
      r_drop         <= '0;
    end else begin
      r_state <= w_next;
      r_cd <= w_issue ? 8'(COOLDOWN_CYC) : r_state == COOLDOWN && r_cd != 8'd0 ? r_cd - 8'd1 : r_cd;
      if (w_next == HALTED) r_ord_valid <= 1'b0;
      else if (w_issue) begin
        r_ord_valid    <= 1'b1;
        r_ord_side     <= !bus.signal_in[31];
        r_ord_strength <= w_abs;
      end else if (w_pop) r_ord_valid <= 1'b0;
      if (r_state != HALTED) r_refill <= w_refill ? 16'd0 : r_refill + 16'd1;
      if (w_refill && !w_issue) r_tokens <= r_tokens == 4'(MAX_ORDERS) ? r_tokens : r_tokens + 4'd1;
      else if (w_issue && !w_refill) r_tokens <= r_tokens - 4'd1;
      if (w_drop && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
    end
  end
  assign bus.ord_valid    = r_ord_valid;
  assign bus.ord_side     = r_ord_side;
  assign bus.ord_strength = r_ord_strength;
  assign bus.state_out    = r_state;
  assign bus.halted       = r_state == HALTED;
  assign bus.drop_count   = r_drop;
endmodule

// File: tb/tb_trade_sequencer.sv
// tb_trade_sequencer: directed vector table plus hand-written multi-cycle sequences
module tb_trade_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  trade_sequencer_if u_if();
  trade_sequencer #(.COOLDOWN_CYC(8), .MAX_ORDERS(4), .REFILL_CYC(200)) dut (
    .clk(clk), .rst_n(rst_n), .bus(u_if.slave)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] sig;
    logic        allow;
    logic        kill;
    logic        e_valid;
    logic        e_side;
    logic [31:0] e_str;
    logic [1:0]  e_state;
  } vec_t;
  vec_t vecs[10];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    u_if.enable = 0; u_if.kill_clear = 0; u_if.in_valid = 0; u_if.signal_in = 0;
    u_if.allow_trade_in = 0; u_if.kill_in = 0; u_if.ord_ready = 0;
    tick();
    rst_n = 1'b1;
  endtask
  task automatic arm();
    u_if.enable = 1'b1;
    tick();
  endtask
  task automatic beat(input logic [31:0] s, input logic a, input logic k);
    u_if.in_valid = 1; u_if.signal_in = s; u_if.allow_trade_in = a; u_if.kill_in = k;
    tick();
    u_if.in_valid = 0; u_if.allow_trade_in = 0; u_if.kill_in = 0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int n;
    int orders;
    vecs[0] = '{32'h0001_0000, 1, 0, 1, 1, 32'h0001_0000, 2'd2};
    vecs[1] = '{32'hFFFF_0000, 1, 0, 1, 0, 32'h0001_0000, 2'd2};
    vecs[2] = '{32'h0000_8000, 1, 0, 0, 0, 32'h0, 2'd1};
    vecs[3] = '{32'h0000_8001, 1, 0, 1, 1, 32'h0000_8001, 2'd2};
    vecs[4] = '{32'hFFFF_8000, 1, 0, 0, 0, 32'h0, 2'd1};
    vecs[5] = '{32'h8000_0000, 1, 0, 1, 0, 32'h7FFF_FFFF, 2'd2};
    vecs[6] = '{32'h0001_0000, 0, 0, 0, 0, 32'h0, 2'd1};
    vecs[7] = '{32'h0001_0000, 1, 1, 0, 0, 32'h0, 2'd3};
    vecs[8] = '{32'h7FFF_FFFF, 1, 0, 1, 1, 32'h7FFF_FFFF, 2'd2};
    vecs[9] = '{32'h0000_0000, 0, 1, 0, 0, 32'h0, 2'd3};
    do_reset();
    chk("rst_state", u_if.state_out, 0);
    chk("rst_valid", u_if.ord_valid, 0);
    chk("rst_side", u_if.ord_side, 0);
    chk("rst_strength", u_if.ord_strength, 0);
    chk("rst_halted", u_if.halted, 0);
    chk("rst_drop", u_if.drop_count, 0);
    chk("rst_in_ready", u_if.in_ready, 1);
    for (int i = 0; i < 10; i++) begin
      do_reset();
      arm();
      chk($sformatf("v%0d_armed", i), u_if.state_out, 1);
      beat(vecs[i].sig, vecs[i].allow, vecs[i].kill);
      chk($sformatf("v%0d_valid", i), u_if.ord_valid, vecs[i].e_valid);
      chk($sformatf("v%0d_state", i), u_if.state_out, vecs[i].e_state);
      chk($sformatf("v%0d_halted", i), u_if.halted, vecs[i].e_state == 2'd3);
      if (vecs[i].e_valid) begin
        chk($sformatf("v%0d_side", i), u_if.ord_side, vecs[i].e_side);
        chk($sformatf("v%0d_strength", i), u_if.ord_strength, vecs[i].e_str);
      end
    end
    do_reset();
    u_if.ord_ready = 1;
    arm();
    beat(32'h0001_0000, 1, 0);
    chk("cd_valid", u_if.ord_valid, 1);
    n = 0;
    while (u_if.state_out == 2'd2 && n < 20) begin
      n++;
      tick();
    end
    chk("cd_len", n, 8);
    chk("cd_back_armed", u_if.state_out, 1);
    chk("cd_popped", u_if.ord_valid, 0);
    do_reset();
    u_if.ord_ready = 1;
    arm();
    orders = 0;
    for (int k = 0; k < 5; k++) begin
      beat(32'h0002_0000, 1, 0);
      if (u_if.ord_valid) orders++;
      if (k == 4) chk("tok_5th_none", u_if.ord_valid, 0);
      repeat (8) tick();
      chk($sformatf("tok_armed%0d", k), u_if.state_out, 1);
    end
    chk("tok_orders", orders, 4);
    chk("tok_drop", u_if.drop_count, 1);
    repeat (200) tick();
    beat(32'h0002_0000, 1, 0);
    chk("tok_refill_order", u_if.ord_valid, 1);
    chk("tok_drop_hold", u_if.drop_count, 1);
    do_reset();
    arm();
    beat(32'h0001_0000, 1, 0);
    tick();
    chk("kill_pending", u_if.ord_valid, 1);
    beat(32'h0, 0, 1);
    chk("kill_state", u_if.state_out, 3);
    chk("kill_valid", u_if.ord_valid, 0);
    chk("kill_halted", u_if.halted, 1);
    u_if.kill_clear = 1;
    beat(32'h0, 0, 1);
    chk("clear_with_kill", u_if.state_out, 3);
    tick();
    u_if.kill_clear = 0;
    chk("clear_state", u_if.state_out, 0);
    chk("clear_halted", u_if.halted, 0);
    do_reset();
    arm();
    beat(32'h0001_0000, 1, 0);
    u_if.enable = 0;
    tick();
    chk("dis_idle", u_if.state_out, 0);
    chk("dis_pending", u_if.ord_valid, 1);
    u_if.ord_ready = 1;
    tick();
    chk("dis_popped", u_if.ord_valid, 0);
    do_reset();
    arm();
    beat(32'h0001_0000, 1, 0);
    repeat (8) tick();
    chk("bp_armed", u_if.state_out, 1);
    chk("bp_in_ready", u_if.in_ready, 0);
    rst_n = 0;
    #1;
    chk("bp_rst_in_ready", u_if.in_ready, 1);
    tick();
    rst_n = 1;
    arm();
    beat(32'h0001_0000, 1, 0);
    tick();
    chk("rcd_cooldown", u_if.state_out, 2);
    rst_n = 0;
    tick();
    chk("rcd_state", u_if.state_out, 0);
    chk("rcd_valid", u_if.ord_valid, 0);
    chk("rcd_side", u_if.ord_side, 0);
    chk("rcd_strength", u_if.ord_strength, 0);
    chk("rcd_halted", u_if.halted, 0);
    chk("rcd_drop", u_if.drop_count, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/trade_sequencer.md
TRADE_SEQUENCER -- requirements
Module: trade_sequencer

Interface
REQ-001 Parameter THRESH, 32'sh0000_8000 (0.5 Q16.16), minimum |signal| that qualifies an order (strict greater-than).
REQ-002 Parameter COOLDOWN_CYC, 8, cycles spent in COOLDOWN after each issued order (range 1..255).
REQ-003 Parameter MAX_ORDERS, 4, token-bucket capacity (range 1..15).
REQ-004 Parameter REFILL_CYC, 16, cycles per token refill (range 2..65535).
REQ-005 clk  in  1  single clock; all state changes on posedge clk.
REQ-006 rst_n  in  1  synchronous, active-low reset.
REQ-007 enable  in  1  level; 1 arms trading, 0 returns to IDLE.
REQ-008 kill_clear  in  1  pulse; releases HALTED.
REQ-009 in_valid / in_ready  in / out  1 / 1  input stream handshake from the pipeline output.
REQ-010 signal_in  in  32  signed Q16.16 trading signal.
REQ-011 allow_trade_in  in  1  risk permission for this beat.
REQ-012 kill_in  in  1  risk kill for this beat.
REQ-013 ord_valid / ord_ready  out / in  1 / 1  order stream handshake.
REQ-014 ord_side  out  1  1 = buy (signal > 0), 0 = sell.
REQ-015 ord_strength  out  32  unsigned |signal_in|, Q16.16.
REQ-016 state_out  out  2  IDLE=0, ARMED=1, COOLDOWN=2, HALTED=3.
REQ-017 halted  out  1  1 iff state == HALTED.
REQ-018 drop_count  out  16  saturating count of qualifying beats rejected for lack of tokens.

Function
REQ-019 A beat is accepted when in_valid && in_ready are both 1 at a clock edge; the order slot is popped when ord_valid && ord_ready are both 1.
REQ-020 Qualifying beat: allow_trade_in=1, kill_in=0, and |signal_in| > THRESH.
REQ-021 |x|: two's-complement negate when negative; 32'h8000_0000 saturates to 32'h7FFF_FFFF.
REQ-022 in_ready: 1 in IDLE, COOLDOWN and HALTED; in ARMED, (!ord_valid || ord_ready).
REQ-023 IDLE: accepted beats are discarded; enable=1 moves to ARMED on the next edge.
REQ-024 ARMED, accepted beat with kill_in=1: go to HALTED; no order is issued.
REQ-025 ARMED, qualifying beat with tokens > 0: load order register (side, strength), set ord_valid=1 on the next edge (1-cycle latency), decrement tokens, load cooldown counter with COOLDOWN_CYC, go to COOLDOWN.
REQ-026 ARMED, qualifying beat with tokens == 0: no order, drop_count +1 (saturates at 16'hFFFF), stay in ARMED.
REQ-027 ARMED, non-qualifying beat without kill: discard silently.
REQ-028 COOLDOWN: counter decrements every cycle; on the edge where it reaches 0, go to ARMED.
REQ-029 COOLDOWN: accepted beats are discarded; kill_in=1 on any accepted beat goes to HALTED.
REQ-030 Kill priority: kill_in on an accepted beat in ARMED/COOLDOWN beats enable=0 and the cooldown expiry.
REQ-031 Entering HALTED clears ord_valid the same edge (pending order cancelled); this is the only case where ord_valid drops without a pop.
REQ-032 HALTED: all beats are discarded; exit to IDLE only on kill_clear=1 with no accepted kill_in beat that cycle (a simultaneous kill keeps HALTED); enable is ignored.
REQ-033 enable=0 in ARMED/COOLDOWN: go to IDLE on the next edge; a pending order remains valid until popped.
REQ-034 Order register holds its value and ord_valid stays 1 until popped (except REQ-031); pop and load on the same edge is legal in ARMED.
REQ-035 Token refill counter runs in all states except HALTED; every REFILL_CYC cycles, tokens +1, saturating at MAX_ORDERS; a simultaneous refill and consume leaves tokens unchanged.
REQ-036 The refill counter holds its value while HALTED and resumes on exit.

Reset
REQ-037 On rst_n=0 at an edge: state=IDLE, ord_valid=0, ord_side=0, ord_strength=0, tokens=MAX_ORDERS, refill counter=0, cooldown counter=0, drop_count=0.
REQ-038 Reset has priority over all inputs, including mid-order and HALTED; in_ready reads 1 while in reset.

Verification
REQ-039 enable=1, beat signal=0x0001_0000, allow=1 -> ord_valid 1 cycle later, side=1, strength=0x0001_0000, state goes to COOLDOWN for 8 cycles, then ARMED.
REQ-040 Beat signal=0xFFFF_0000 (-1.0) -> side=0, strength=0x0001_0000; beat signal=0x0000_8000 (equals THRESH) -> no order.
REQ-041 Five qualifying beats spaced 9 cycles apart, ord_ready=1, REFILL_CYC large -> 4 orders, then drop_count=1.
REQ-042 Pending order with ord_ready=0, then a kill_in beat -> ord_valid falls on the same edge as HALTED is entered; kill_clear with a concurrent kill beat -> stays HALTED; kill_clear alone -> IDLE.
REQ-043 signal=0x8000_0000 -> strength=0x7FFF_FFFF; rst_n=0 during COOLDOWN -> all outputs at reset values on the next edge.
